// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: code table, FSM states
// and the pattern-to-nibble lookup.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    // Active-low segment codes with dp off; bits [7:1] are a..g.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [4:0] seg_lookup(input logic [6:0] code);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_CODES[i][7:1] == code) result = {1'b1, 4'(i)};
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational decode of the a..g segment lines into a hex nibble plus a
// hit flag for recognised patterns.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [7:1] seg,
    output logic       hit,
    output logic [3:0] nib
);

    logic [4:0] w_lookup;

    assign w_lookup = seg_lookup(seg);
    assign hit      = w_lookup[4];
    assign nib      = w_lookup[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus and recovers per-digit value, decimal
// point and bad-pattern flags, pulsing frame_valid once every digit is seen.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     bad,
    output logic [DIGITS-1:0]     seen,
    output logic                  frame_valid
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(SETTLE);

    logic [7:0]        r_seg_meta, r_seg_sync, r_seg_prev;
    logic [DIGITS-1:0] r_an_meta, r_an_sync, r_an_prev;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;

    logic              w_hit;
    logic [3:0]        w_nib;
    logic              w_an_valid;
    logic              w_changed;
    logic              w_load;
    logic              w_capture;
    logic [IW-1:0]     w_idx;
    logic [DIGITS-1:0] w_seen_base;

    seg7_pattern_dec u_dec (
        .seg (r_seg_sync[7:1]),
        .hit (w_hit),
        .nib (w_nib)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_an_sync[i]) w_idx = IW'(i);
        end
    end

    assign w_an_valid  = $onehot(~r_an_sync);
    assign w_changed   = (r_an_sync != r_an_prev) || (r_seg_sync != r_seg_prev);
    assign w_load      = w_an_valid && ((r_state == ST_IDLE) || w_changed);
    // A one-cycle settle window captures on the very edge the count loads.
    assign w_capture   = w_an_valid &&
                         ((w_load && (SETTLE == 1)) ||
                          ((r_state == ST_SETTLE) && !w_changed &&
                           ((r_cnt + CNT_ONE) == CNT_DONE)));
    assign w_seen_base = (&seen) ? '0 : seen;

    // NOTE: sequential state uses non-blocking assignments only; the capture
    // registers are reset too, so no partial frame survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_meta <= '0;
            r_seg_sync <= '0;
            r_seg_prev <= '0;
            r_an_meta  <= '0;
            r_an_sync  <= '0;
            r_an_prev  <= '0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
        end else begin
            r_seg_meta <= seg;
            r_seg_sync <= r_seg_meta;
            r_seg_prev <= r_seg_sync;
            r_an_meta  <= an;
            r_an_sync  <= r_an_meta;
            r_an_prev  <= r_an_sync;
            if (!w_an_valid) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_capture) begin
                r_state <= ST_HOLD;
                r_cnt   <= CNT_DONE;
            end else if (w_load) begin
                r_state <= ST_SETTLE;
                r_cnt   <= CNT_ONE;
            end else if (r_state == ST_SETTLE) begin
                r_cnt   <= r_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            dp          <= '0;
            bad         <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= &seen;
            if (w_capture) begin
                seen       <= w_seen_base | (DIGITS'(1) << w_idx);
                dp[w_idx]  <= ~r_seg_sync[0];
                bad[w_idx] <= ~w_hit;
                if (w_hit) value[{w_idx, 2'b00} +: 4] <= w_nib;
            end else begin
                seen       <= w_seen_base;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus a random
// scan compared against a cycle-level behavioural model of the display bus.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg, seg1;
    logic [7:0]  an, an1;
    logic [31:0] value, value1;
    logic [7:0]  dp, dp1, bad, bad1, seen, seen1;
    logic        frame_valid, fv1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(8), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .value(value), .dp(dp),
        .bad(bad), .seen(seen), .frame_valid(frame_valid)
    );

    seg7_scan_decoder #(.DIGITS(8), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .seg(seg1), .an(an1), .value(value1), .dp(dp1),
        .bad(bad1), .seen(seen1), .frame_valid(fv1)
    );

    logic [7:0] codes [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Reference model: what the display shows, when it becomes capturable.
    typedef struct {
        int         at;
        int         idx;
        logic [7:0] code;
    } cap_t;

    cap_t       pend[$];
    logic [3:0] m_val [8];
    bit         m_dp  [8];
    bit         m_bad [8];
    bit   [7:0] m_seen;
    bit         m_fv;
    logic [7:0] cur_an, cur_seg;
    int         run_start, run_len;
    int         edge_n = 0;
    int         fv_obs[$];
    int         fv_exp[$];

    function automatic bit [4:0] ref_decode(input logic [7:0] s);
        bit [4:0] r;
        r = 5'h0;
        for (int i = 0; i < 16; i++) begin
            if (codes[i][7:1] == s[7:1]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic bit onehot_low(input logic [7:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic int low_idx(input logic [7:0] a);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) if (!a[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] exp_value();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = m_val[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_dp();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_dp[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_bad();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_bad[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_val[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_bad[i] = 1'b0;
        end
        m_seen  = 8'h00;
        m_fv    = 1'b0;
        pend.delete();
        cur_an  = 8'hFF;
        cur_seg = 8'hFF;
        run_start = edge_n;
        run_len   = 0;
    endtask

    // Advance the model across one rising edge on which the current pins are sampled.
    task automatic model_edge();
        cap_t     c;
        bit [4:0] d;
        m_fv = (m_seen == 8'hFF);
        if (m_fv) m_seen = 8'h00;
        while (pend.size() > 0 && pend[0].at == edge_n) begin
            c = pend.pop_front();
            d = ref_decode(c.code);
            if (d[4]) begin
                m_val[c.idx] = d[3:0];
                m_bad[c.idx] = 1'b0;
            end else begin
                m_bad[c.idx] = 1'b1;
            end
            m_dp[c.idx]   = ~c.code[0];
            m_seen[c.idx] = 1'b1;
        end
        if (!rst) begin
            run_len++;
            if (run_len == S && onehot_low(cur_an))
                pend.push_back('{run_start + 2 + S, low_idx(cur_an), cur_seg});
        end
    endtask

    task automatic set_pins(input logic [7:0] a, input logic [7:0] s);
        if (a !== cur_an || s !== cur_seg) begin
            cur_an    = a;
            cur_seg   = s;
            run_start = edge_n;
            run_len   = 0;
        end
        an  = a;
        seg = s;
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        if (frame_valid) fv_obs.push_back(edge_n);
        if (m_fv) fv_exp.push_back(edge_n);
    endtask

    task automatic dwell(input logic [7:0] a, input logic [7:0] s, input int d);
        set_pins(a, s);
        repeat (d) step();
    endtask

    task automatic do_reset();
        set_pins(8'hFF, 8'hFF);
        an1  = 8'hFF;
        seg1 = 8'hFF;
        rst  = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        fv_obs.delete();
        fv_exp.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an = 8'hFF; seg = 8'hFF; an1 = 8'hFF; seg1 = 8'hFF;
        model_reset();
        #1;
        n_checks++; if (value !== 32'h0) begin n_errors++; $display("FAIL reset_value: got %h expected 0", value); end
        n_checks++; if (dp !== 8'h0) begin n_errors++; $display("FAIL reset_dp: got %h expected 0", dp); end
        n_checks++; if (bad !== 8'h0) begin n_errors++; $display("FAIL reset_bad: got %h expected 0", bad); end
        n_checks++; if (seen !== 8'h0) begin n_errors++; $display("FAIL reset_seen: got %h expected 0", seen); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        @(negedge clk);
        do_reset();
        dwell(8'hFE, codes[3], 8);
        dwell(8'hFD, codes[10], 8);
        dwell(8'hFB, codes[5], 8);
        dwell(8'hF7, codes[12], 8);
        n_checks++; if (value[15:0] !== 16'hC5A3) begin n_errors++; $display("FAIL partial_value: got %h expected c5a3", value[15:0]); end
        n_checks++; if (seen !== 8'h0F) begin n_errors++; $display("FAIL partial_seen: got %h expected 0f", seen); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (value !== 32'h0) begin n_errors++; $display("FAIL async_value: got %h expected 0", value); end
        n_checks++; if (dp !== 8'h0) begin n_errors++; $display("FAIL async_dp: got %h expected 0", dp); end
        n_checks++; if (bad !== 8'h0) begin n_errors++; $display("FAIL async_bad: got %h expected 0", bad); end
        n_checks++; if (seen !== 8'h0) begin n_errors++; $display("FAIL async_seen: got %h expected 0", seen); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL async_fv: got %b expected 0", frame_valid); end
        model_reset();
        set_pins(8'hFF, 8'hFF);
        step();
        step();
        rst = 1'b0;
        for (int k = 4; k < 8; k++) dwell(~(8'(1) << k), codes[k], 8);
        dwell(8'hFF, 8'hFF, 8);
        n_checks++; if (fv_obs.size() != 0) begin n_errors++; $display("FAIL post_reset_fv: got %0d pulses expected 0", fv_obs.size()); end
        n_checks++; if (seen !== 8'hF0) begin n_errors++; $display("FAIL post_reset_seen: got %h expected f0", seen); end
    endtask

    task automatic test_full_scan();
        int s7;
        do_reset();
        s7 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) s7 = edge_n;
            dwell(~(8'(1) << k), codes[k], 10);
        end
        dwell(8'hFF, 8'hFF, 6);
        n_checks++; if (value !== 32'h76543210) begin n_errors++; $display("FAIL scan_value: got %h expected 76543210", value); end
        n_checks++; if (dp !== 8'h00) begin n_errors++; $display("FAIL scan_dp: got %h expected 00", dp); end
        n_checks++; if (bad !== 8'h00) begin n_errors++; $display("FAIL scan_bad: got %h expected 00", bad); end
        n_checks++; if (seen !== 8'h00) begin n_errors++; $display("FAIL scan_seen: got %h expected 00", seen); end
        n_checks++;
        if (fv_obs.size() != 1) begin
            n_errors++; $display("FAIL scan_fv_count: got %0d pulses expected 1", fv_obs.size());
        end else if (fv_obs[0] != s7 + 2 + S + 1) begin
            n_errors++; $display("FAIL scan_fv_edge: got edge %0d expected %0d", fv_obs[0], s7 + 3 + S);
        end
    endtask

    task automatic test_short_dwell();
        do_reset();
        dwell(8'hFB, codes[9], S - 1);
        dwell(8'hFF, 8'hFF, 4);
        dwell(8'hFB, codes[9], 5);
        n_checks++; if (value !== 32'h0 || seen !== 8'h00) begin n_errors++; $display("FAIL short_early: got value %h seen %h expected 0 0", value, seen); end
        dwell(8'hFB, codes[9], 1);
        n_checks++; if (value[11:8] !== 4'h9) begin n_errors++; $display("FAIL short_capture: got %h expected 9", value[11:8]); end
        n_checks++; if (seen !== 8'h04) begin n_errors++; $display("FAIL short_seen: got %h expected 04", seen); end
    endtask

    task automatic test_bad_dp();
        do_reset();
        dwell(8'hDF, codes[7], 8);
        dwell(8'hDF, 8'hFF, 8);
        n_checks++; if (bad[5] !== 1'b1) begin n_errors++; $display("FAIL bad_set: got %b expected 1", bad[5]); end
        n_checks++; if (value[23:20] !== 4'h7) begin n_errors++; $display("FAIL bad_keep: got %h expected 7", value[23:20]); end
        n_checks++; if (dp[5] !== 1'b0 || seen[5] !== 1'b1) begin n_errors++; $display("FAIL bad_dp_seen: got dp %b seen %b expected 0 1", dp[5], seen[5]); end
        dwell(8'hDF, 8'h84, 8);
        n_checks++; if (value[23:20] !== 4'hD) begin n_errors++; $display("FAIL dp_value: got %h expected d", value[23:20]); end
        n_checks++; if (dp[5] !== 1'b1) begin n_errors++; $display("FAIL dp_on: got %b expected 1", dp[5]); end
        n_checks++; if (bad[5] !== 1'b0) begin n_errors++; $display("FAIL bad_clear: got %b expected 0", bad[5]); end
    endtask

    task automatic test_glitch();
        do_reset();
        dwell(8'hFD, codes[3], 2);
        dwell(8'hFD, codes[8], 1);
        dwell(8'hFD, codes[3], 5);
        n_checks++; if (value[7:4] !== 4'h0 || seen !== 8'h00) begin n_errors++; $display("FAIL glitch_early: got value %h seen %h expected 0 0", value[7:4], seen); end
        dwell(8'hFD, codes[3], 1);
        n_checks++; if (value[7:4] !== 4'h3 || seen !== 8'h02) begin n_errors++; $display("FAIL glitch_capture: got value %h seen %h expected 3 02", value[7:4], seen); end
        dwell(8'hFC, codes[6], 12);
        n_checks++; if (value !== 32'h30 || seen !== 8'h02) begin n_errors++; $display("FAIL two_low: got value %h seen %h expected 30 02", value, seen); end
    endtask

    task automatic test_random();
        logic [7:0] a, s;
        int r, x, y;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                a = ~(8'(1) << r);
            end else if (r == 8) begin
                a = 8'hFF;
            end else begin
                x = $urandom_range(0, 7);
                y = (x + 1 + $urandom_range(0, 6)) % 8;
                a = ~((8'(1) << x) | (8'(1) << y));
            end
            if ($urandom_range(0, 3) != 0) s = codes[$urandom_range(0, 15)] ^ 8'($urandom_range(0, 1));
            else s = 8'($urandom);
            dwell(a, s, $urandom_range(1, S + 6));
            n_checks++; if (value !== exp_value()) begin n_errors++; $display("FAIL rand_value[%0d]: got %h expected %h", it, value, exp_value()); end
            n_checks++; if (dp !== exp_dp()) begin n_errors++; $display("FAIL rand_dp[%0d]: got %h expected %h", it, dp, exp_dp()); end
            n_checks++; if (bad !== exp_bad()) begin n_errors++; $display("FAIL rand_bad[%0d]: got %h expected %h", it, bad, exp_bad()); end
            n_checks++; if (seen !== m_seen) begin n_errors++; $display("FAIL rand_seen[%0d]: got %h expected %h", it, seen, m_seen); end
        end
        dwell(8'hFF, 8'hFF, 10);
        n_checks++; if (fv_obs != fv_exp) begin n_errors++; $display("FAIL rand_frames: got %0d pulses expected %0d", fv_obs.size(), fv_exp.size()); end
    endtask

    task automatic test_strobe_capture();
        int e, s7, d;
        int fv_at[$];
        logic [7:0] seen_at_e;
        do_reset();
        e = 0;
        s7 = -100;
        seen_at_e = 8'h00;
        for (int k = 0; k < 9; k++) begin
            if (k == 7) s7 = e;
            an1  = (k == 8) ? 8'hFE : ~(8'(1) << k);
            seg1 = (k == 8) ? codes[5] : codes[k];
            d    = (k == 7) ? 1 : ((k == 8) ? 4 : 3);
            repeat (d) begin
                @(posedge clk);
                e++;
                @(negedge clk);
                if (fv1) fv_at.push_back(e);
                if (e == s7 + 3) seen_at_e = seen1;
            end
        end
        an1 = 8'hFF;
        seg1 = 8'hFF;
        repeat (3) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (fv1) fv_at.push_back(e);
        end
        n_checks++; if (seen_at_e !== 8'hFF) begin n_errors++; $display("FAIL strobe_full: got %h expected ff", seen_at_e); end
        n_checks++;
        if (fv_at.size() != 1) begin
            n_errors++; $display("FAIL strobe_fv_count: got %0d pulses expected 1", fv_at.size());
        end else if (fv_at[0] != s7 + 4) begin
            n_errors++; $display("FAIL strobe_fv_edge: got edge %0d expected %0d", fv_at[0], s7 + 4);
        end
        n_checks++; if (seen1 !== 8'h01) begin n_errors++; $display("FAIL strobe_seen: got %h expected 01", seen1); end
        n_checks++; if (value1 !== 32'h76543215) begin n_errors++; $display("FAIL strobe_value: got %h expected 76543215", value1); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_short_dwell();
        test_bad_dp();
        test_glitch();
        test_random();
        test_strobe_capture();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
